synchronizer_bank: RTL and testbench

//  Multi-channel, parametrised-depth synchroniser for asynchronous level inputs (switches, status pins,

---
 rtl/synchronizer_bank.sv | 130 +++++++++++++
 tb/tb_synchronizer_bank.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/synchronizer_bank.sv
// synchronizer_bank: multi-channel level synchroniser for asynchronous inputs
// entering the clk domain. Every channel has a DEPTH-flop chain, a registered
// output level q, and single-cycle rise/fall pulses derived from the value q
// is about to load. `changed` is the OR of all pulses, registered with them.
//
// Optional glitch filter, enabled by defining SYNCHRONIZER_BANK_FILTER_EN:
// q[i] only follows the synchronised level once it has differed from q[i]
// for FILTER_CYCLES consecutive cycles. With FILTER_CYCLES=1 the filtered
// build behaves cycle-for-cycle like the unfiltered one.
//
// Reset is synchronous and active-high. It dominates every other update.
// The chain, q and the filter reference all load RESET_VAL, so release never
// produces a spurious edge pulse.
module synchronizer_bank #(
  parameter int               WIDTH         = 4,
  parameter int               DEPTH         = 2,
  parameter int               FILTER_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  // Synchroniser chain. Kept free of logic between stages so the flops
  // can be placed back-to-back for metastability resolution.
  (* preserve *) logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] s;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             changed_q, changed_d;

  // Shift the asynchronous inputs through the chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= RESET_VAL;
      end
    end else begin
      stage_q[0] <= d;
      for (int k = 1; k < DEPTH; k++) begin
        stage_q[k] <= stage_q[k-1];
      end
    end
  end

  assign s = stage_q[DEPTH-1];

`ifdef SYNCHRONIZER_BANK_FILTER_EN
  localparam int CW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic [CW-1:0] cnt_q [WIDTH];
  logic [CW-1:0] cnt_d [WIDTH];

  // Filter: count consecutive cycles of disagreement between s and q.
  // q accepts s once the disagreement has lasted FILTER_CYCLES cycles.
  always_comb begin
    q_d = q_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s[i] != q_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          q_d[i] = s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Filter counters. Reset discards any partially accumulated count.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
`else
  // The plain path: q follows the last chain stage every cycle.
  // FILTER_CYCLES has no meaning without the filter.
  logic unused_cfg;
  assign unused_cfg = (FILTER_CYCLES > 0);

  // The plain path needs no state of its own. q loads s every cycle.
  always_comb begin
    q_d = s;
  end
`endif

  // Edge detection on the value q is about to load. The pulses then line up
  // with the first cycle q shows its new level.
  always_comb begin
    rise_d    = q_d & ~q_q;
    fall_d    = ~q_d & q_q;
    changed_d = |(rise_d | fall_d);
  end

  // Output registers for the level, the edge pulses and the summary flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q       <= RESET_VAL;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end

  assign q       = q_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_synchronizer_bank.sv
// Bench for synchronizer_bank (WIDTH=4, DEPTH=3, FILTER_CYCLES=4, RESET_VAL=4'b1010).
// When SYNCHRONIZER_BANK_FILTER_EN is defined, the filter scenario is added
// and the expected latency grows by FILTER_CYCLES-1.
`timescale 1ns/1ps
module tb_synchronizer_bank;

  localparam int W   = 4;
  localparam int DEPTH = 3;
  localparam int FC  = 4;
  localparam logic [W-1:0] RV = 4'b1010;
`ifdef SYNCHRONIZER_BANK_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif
  // Edges from the sampling edge of d until q shows the new level.
  localparam int LAT = FILT ? DEPTH + FC - 1 : DEPTH;
  // Cycles to leave a rising d[2] in flight before the mid-run reset.
  localparam int PRE = FILT ? DEPTH + 2 : DEPTH - 1;
  localparam int SBW = 3*W + 1;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] d;
  logic [W-1:0] q, rise, fall;
  logic         changed;

  always #5 clk = ~clk;

  synchronizer_bank #(
    .WIDTH(W), .DEPTH(DEPTH), .FILTER_CYCLES(FC), .RESET_VAL(RV)
  ) dut (
    .clk(clk), .reset(reset), .d(d),
    .q(q), .rise(rise), .fall(fall), .changed(changed)
  );

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [SBW-1:0] exp_q[$];
  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state (behaviour of the device as described, per edge).
  logic [W-1:0] m_stage [DEPTH];
  logic [W-1:0] m_q;
  int           m_cnt [W];

  task automatic model_edge(input logic rst, input logic [W-1:0] dv,
                            output logic [SBW-1:0] e);
    logic [W-1:0] s, nq, r, f;
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) m_stage[k] = RV;
      for (int i = 0; i < W; i++) m_cnt[i] = 0;
      m_q = RV;
      e = {RV, {W{1'b0}}, {W{1'b0}}, 1'b0};
    end else begin
      s  = m_stage[DEPTH-1];
      nq = m_q;
      for (int i = 0; i < W; i++) begin
        if (!FILT) nq[i] = s[i];
        else if (s[i] == m_q[i]) m_cnt[i] = 0;
        else if (m_cnt[i] == FC - 1) begin
          nq[i] = s[i];
          m_cnt[i] = 0;
        end else m_cnt[i] = m_cnt[i] + 1;
      end
      r = nq & ~m_q;
      f = ~nq & m_q;
      for (int k = DEPTH - 1; k > 0; k--) m_stage[k] = m_stage[k-1];
      m_stage[0] = dv;
      m_q = nq;
      e = {nq, r, f, |(r | f)};
    end
  endtask

  // ---------------- driver / monitor ----------------
  // One clock cycle: optional intra-cycle glitching of d, settle on dv before
  // the edge, push the model prediction, then sample #1 after the edge.
  task automatic cycle(input logic rst, input logic [W-1:0] dv, input bit jitter);
    logic [SBW-1:0] e, got, want;
    if (jitter) begin
      #($urandom_range(0, 3));
      d = W'($urandom_range(0, 15));
      #($urandom_range(1, 3));
    end
    reset = rst;
    d     = dv;
    model_edge(rst, dv, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got  = {q, rise, fall, changed};
    want = exp_q.pop_front();
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL scoreboard t=%0t q/rise/fall/chg got %b %b %b %b want %b %b %b %b",
               $time, got[SBW-1 -: W], got[2*W -: W], got[W -: W], got[0],
               want[SBW-1 -: W], want[2*W -: W], want[W -: W], want[0]);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int k = 0; k < 7; k++) begin
      cycle(k < 3, RV, 1'b0);
      n_vec++;
      if ({q, rise, fall, changed} !== {RV, 9'b0}) begin
        n_miss++;
        $display("FAIL reset cyc=%0d got q=%b r=%b f=%b c=%b want q=%b pulses 0",
                 k, q, rise, fall, changed, RV);
      end
    end
  endtask

  task automatic test_latency();
    logic [W-1:0] hi = RV | 4'b0001;
    for (int k = 0; k <= LAT + 2; k++) begin
      cycle(1'b0, hi, 1'b0);
      n_vec++;
      if ({q[0], rise, fall, changed} !== {(k >= LAT), (k == LAT) ? 4'b0001 : 4'b0000,
                                           4'b0000, (k == LAT)}) begin
        n_miss++;
        $display("FAIL latency_rise k=%0d got q0=%b r=%b f=%b c=%b want q0=%0d rise at k=%0d",
                 k, q[0], rise, fall, changed, (k >= LAT), LAT);
      end
    end
    for (int k = 0; k <= LAT + 2; k++) begin
      cycle(1'b0, RV, 1'b0);
      n_vec++;
      if ({q[0], rise, fall, changed} !== {(k < LAT), 4'b0000,
                                           (k == LAT) ? 4'b0001 : 4'b0000, (k == LAT)}) begin
        n_miss++;
        $display("FAIL latency_fall k=%0d got q0=%b r=%b f=%b c=%b want q0=%0d fall at k=%0d",
                 k, q[0], rise, fall, changed, (k < LAT), LAT);
      end
    end
  endtask

  task automatic test_simultaneous();
    for (int k = 0; k < LAT + 2; k++) cycle(1'b0, 4'b0000, 1'b0);
    for (int k = 0; k <= LAT + 1; k++) begin
      cycle(1'b0, 4'b0101, 1'b0);
      n_vec++;
      if ({rise, fall, changed} !== {(k == LAT) ? 4'b0101 : 4'b0000, 4'b0000, (k == LAT)}) begin
        n_miss++;
        $display("FAIL simul_rise k=%0d got r=%b f=%b c=%b", k, rise, fall, changed);
      end
    end
    for (int k = 0; k <= LAT + 1; k++) begin
      cycle(1'b0, 4'b0011, 1'b0);
      n_vec++;
      if ({q, rise, fall, changed} !== {(k >= LAT) ? 4'b0011 : 4'b0101,
                                        (k == LAT) ? 4'b0010 : 4'b0000,
                                        (k == LAT) ? 4'b0100 : 4'b0000, (k == LAT)}) begin
        n_miss++;
        $display("FAIL simul_mixed k=%0d got q=%b r=%b f=%b c=%b", k, q, rise, fall, changed);
      end
    end
  endtask

`ifdef SYNCHRONIZER_BANK_FILTER_EN
  task automatic test_filter();
    for (int k = 0; k < LAT + 2; k++) cycle(1'b0, 4'b0000, 1'b0);
    // Glitch one cycle short of the filter length: must be swallowed.
    for (int k = 0; k < FC - 1 + LAT + 4; k++) begin
      cycle(1'b0, (k < FC - 1) ? 4'b0010 : 4'b0000, 1'b0);
      n_vec++;
      if ({q, rise, fall, changed} !== 13'b0) begin
        n_miss++;
        $display("FAIL filter_glitch k=%0d got q=%b r=%b f=%b c=%b want all 0",
                 k, q, rise, fall, changed);
      end
    end
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 4'b0010, 1'b0);
      n_vec++;
      if ({q, rise, changed} !== {(k >= LAT) ? 4'b0010 : 4'b0000,
                                  (k == LAT) ? 4'b0010 : 4'b0000, (k == LAT)}) begin
        n_miss++;
        $display("FAIL filter_pass k=%0d got q=%b r=%b c=%b want rise at k=%0d",
                 k, q, rise, changed, LAT);
      end
    end
  endtask
`endif

  task automatic test_reset_mid();
    for (int k = 0; k < LAT + 2; k++) cycle(1'b0, 4'b0000, 1'b0);
    for (int k = 0; k < PRE; k++) cycle(1'b0, 4'b0100, 1'b0);
    cycle(1'b1, 4'b0100, 1'b0);
    n_vec++;
    if ({q, rise, fall, changed} !== {RV, 9'b0}) begin
      n_miss++;
      $display("FAIL reset_mid_cycle got q=%b r=%b f=%b c=%b want q=%b", q, rise, fall, changed, RV);
    end
    for (int k = 0; k <= LAT + 1; k++) begin
      cycle(1'b0, 4'b0100, 1'b0);
      n_vec++;
      if ({q, rise, fall, changed} !== {(k >= LAT) ? 4'b0100 : RV,
                                        (k == LAT) ? 4'b0100 : 4'b0000,
                                        (k == LAT) ? 4'b1010 : 4'b0000, (k == LAT)}) begin
        n_miss++;
        $display("FAIL reset_mid_after k=%0d got q=%b r=%b f=%b c=%b", k, q, rise, fall, changed);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] prev_q = q;
    logic [W-1:0] dv = d;
    int           run [W];
    logic         rst;
    for (int i = 0; i < W; i++) run[i] = FC;
    for (int c = 0; c < 10000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 3) == 0) dv = W'($urandom_range(0, 15));
      cycle(rst, dv, 1'($urandom_range(0, 1)));
      if (!rst) begin
        n_vec++;
        if ({rise, fall, changed} !== {q & ~prev_q, ~q & prev_q, |(q ^ prev_q)}) begin
          n_miss++;
          $display("FAIL random_pulse c=%0d q=%b prev=%b got r=%b f=%b c=%b",
                   c, q, prev_q, rise, fall, changed);
        end
      end
      for (int i = 0; i < W; i++) begin
        if (rst) run[i] = 1;
        else if (q[i] !== prev_q[i]) begin
`ifdef SYNCHRONIZER_BANK_FILTER_EN
          n_vec++;
          if (run[i] < FC) begin
            n_miss++;
            $display("FAIL random_hold c=%0d ch=%0d held %0d cycles want >= %0d", c, i, run[i], FC);
          end
`endif
          run[i] = 1;
        end else run[i] = run[i] + 1;
      end
      prev_q = q;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    d     = RV;
    test_reset();
    test_latency();
    test_simultaneous();
`ifdef SYNCHRONIZER_BANK_FILTER_EN
    test_filter();
`endif
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
